// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Package  : div_pkg
// Brief    : Shared state encodings and constants for the sequential divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

   localparam int         DIV_WIDTH    = 16;
   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_RUN        = 2'd1;
   localparam logic [1:0] S_DONE       = 2'd2;
   localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/cla_16bit.sv
`default_nettype none
// ============================================================================
// Module   : cla_16bit
// Brief    : 16-bit carry-lookahead adder, four 4-bit lookahead groups.
// Revision : 1.0
// ============================================================================
module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [4:0]  grp_c;

   assign g = a & b;
   assign p = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_grp
         logic [3:0] gg;
         logic [3:0] pp;
         logic [3:0] cc;

         assign gg = g[4*gi +: 4];
         assign pp = p[4*gi +: 4];

         assign cc[0] = grp_c[gi];
         assign cc[1] = gg[0] | (pp[0] & grp_c[gi]);
         assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_c[gi]);
         assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & grp_c[gi]);

         assign sum[4*gi +: 4] = pp ^ cc;

         assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                          | (pp[3] & pp[2] & pp[1] & gg[0]);
         assign grp_p[gi] = &pp;
      end
   endgenerate

   // Second-level lookahead across the four groups.
   assign grp_c[0] = cin;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
   assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

   assign cout = grp_c[4];

endmodule : cla_16bit
`default_nettype wire

// File: rtl/seq_divider_16bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_16bit
// Brief    : Iterative unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
module seq_divider_16bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] q_reg_q, q_reg_d;
   logic [WIDTH-1:0] r_reg_q, r_reg_d;
   logic [WIDTH-1:0] d_reg_q, d_reg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] shift_lo;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             accept;

   // Low 16 bits of the shifted partial remainder; bit 16 is r_reg_q[15].
   assign shift_lo = {r_reg_q[WIDTH-2:0], q_reg_q[WIDTH-1]};

   cla_16bit u_cla (
      .a    (shift_lo),
      .b    (~d_reg_q),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   assign accept = r_reg_q[WIDTH-1] | cout;

   always_comb begin
      state_d = state_q;
      q_reg_d = q_reg_q;
      r_reg_d = r_reg_q;
      d_reg_d = d_reg_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  state_d = ST_RUN;
                  q_reg_d = dividend;
                  r_reg_d = '0;
                  d_reg_d = divisor;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_DONE;
                  quot_d  = DBZ_QUOTIENT;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            r_reg_d = accept ? diff : shift_lo;
            q_reg_d = {q_reg_q[WIDTH-2:0], accept};
            cnt_d   = cnt_q + 1'b1;
            // Results are published on entry to DONE so they are valid with done.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = ST_DONE;
               quot_d  = q_reg_d;
               rem_d   = r_reg_d;
               dbz_d   = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         q_reg_q <= '0;
         r_reg_q <= '0;
         d_reg_q <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_reg_q <= q_reg_d;
         r_reg_q <= r_reg_d;
         d_reg_q <= d_reg_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule : seq_divider_16bit
`default_nettype wire
